// File: rtl/axi_ram_pkg.sv
// Shared definitions for the axi_ram AXI4 memory slave.
// Holds AXI burst/response encodings and the write/read engine state types.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } write_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } read_state_t;

endpackage

// File: rtl/axi_ram_mem.sv
// Simple dual-port RAM: byte-enabled synchronous write port and a registered read port
// with read-enable. The read register holds its value while re_i is low, which lets the
// R channel stall without re-reading. Same-cycle read/write to one word returns old data.
//
// Ports:
//   clk      clock
//   we_i     write enable, wstrb_i selects the bytes written at waddr_i
//   re_i     read enable, rdata_o updates from raddr_i on the next rising edge
module axi_ram_mem #(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned WORD_ADDR_WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [WORD_ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic [DATA_WIDTH/8-1:0]    wstrb_i,
  input  logic                       re_i,
  input  logic [WORD_ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned Depth     = 2 ** WORD_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < StrbWidth; i++) begin
        if (wstrb_i[i]) begin
          mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_ram.sv
// AXI4 memory-mapped slave backed by an on-chip byte-enabled RAM.
// Independent write (AW/W/B) and read (AR/R) engines, each serving one burst at a time.
// FIXED bursts keep the address, INCR and WRAP advance by 2^size. Responses are always OKAY.
// Address bits at and above MEM_ADDR_WIDTH are ignored, so higher addresses alias.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axi_aw*, s_axi_w*, s_axi_b*   AXI4 write address / data / response channels
//   s_axi_ar*, s_axi_r*             AXI4 read address / data channels
//   lock, cache, prot and wlast are accepted but ignored; beats are counted from len.
//
// Build option:
//   AXI_RAM_PIPELINE_OUTPUT_EN  adds an output register on R (first rvalid two cycles
//                               after the AR handshake, full throughput kept).
module axi_ram
  import axi_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned ID_WIDTH       = 12,
  parameter int unsigned MEM_ADDR_WIDTH = 20,
  localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Write address
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [1:0]            s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  // Write data
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  // Write response
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  // Read address
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic [1:0]            s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  // Read data
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned ByteBits  = $clog2(STRB_WIDTH);
  localparam int unsigned WordAddrW = MEM_ADDR_WIDTH - ByteBits;

  function automatic logic [WordAddrW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[MEM_ADDR_WIDTH-1:ByteBits];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
    if (burst == BURST_FIXED) begin
      return a;
    end
    // INCR, WRAP and the reserved encoding all advance
    return a + (ADDR_WIDTH'(1) << size);
  endfunction

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot};

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  write_state_t          w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  // Handshake outputs are registered from the next state so they are low in reset
  logic                  awready_q, wready_q, bvalid_q;
  logic                  mem_we;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          w_id_d    = s_axi_awid;
          w_addr_d  = s_axi_awaddr;
          w_len_d   = s_axi_awlen;
          w_size_d  = s_axi_awsize;
          w_burst_d = s_axi_awburst;
          w_cnt_d   = 8'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we   = 1'b1;
          w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
          w_cnt_d  = w_cnt_q + 8'd1;
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready && bvalid_q) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      bvalid_q  <= (w_state_d == W_RESP);
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = RESP_OKAY;

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  read_state_t           r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  arready_q, rvalid_int_q;
  logic                  rlast_int;
  logic                  r_ready_int;   // downstream accepts the current RAM output beat
  logic                  mem_re;
  logic [WordAddrW-1:0]  mem_raddr;
  logic [ADDR_WIDTH-1:0] r_addr_next;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign r_addr_next = next_addr(r_addr_q, r_size_q, r_burst_q);

  // The RAM read for a beat is issued on the handshake that retires the previous beat,
  // so the read register holds stable data while the beat is stalled.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    mem_re    = 1'b0;
    mem_raddr = word_idx(r_addr_q);
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          r_id_d    = s_axi_arid;
          r_addr_d  = s_axi_araddr;
          r_len_d   = s_axi_arlen;
          r_size_d  = s_axi_arsize;
          r_burst_d = s_axi_arburst;
          r_cnt_d   = 8'd0;
          mem_re    = 1'b1;
          mem_raddr = word_idx(s_axi_araddr);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_int_q && r_ready_int) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_addr_d  = r_addr_next;
            r_cnt_d   = r_cnt_q + 8'd1;
            mem_re    = 1'b1;
            mem_raddr = word_idx(r_addr_next);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q    <= R_IDLE;
      r_id_q       <= '0;
      r_addr_q     <= '0;
      r_len_q      <= '0;
      r_size_q     <= '0;
      r_burst_q    <= '0;
      r_cnt_q      <= '0;
      arready_q    <= 1'b0;
      rvalid_int_q <= 1'b0;
    end else begin
      r_state_q    <= r_state_d;
      r_id_q       <= r_id_d;
      r_addr_q     <= r_addr_d;
      r_len_q      <= r_len_d;
      r_size_q     <= r_size_d;
      r_burst_q    <= r_burst_d;
      r_cnt_q      <= r_cnt_d;
      arready_q    <= (r_state_d == R_IDLE);
      rvalid_int_q <= (r_state_d == R_DATA);
    end
  end

  assign rlast_int     = rvalid_int_q && (r_cnt_q == r_len_q);
  assign s_axi_arready = arready_q;
  assign s_axi_rresp   = RESP_OKAY;

`ifdef AXI_RAM_PIPELINE_OUTPUT_EN
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic [ID_WIDTH-1:0]   out_id_q;

  // Output register refills in the same cycle it drains, keeping full throughput
  assign r_ready_int = !out_valid_q || s_axi_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else if (rvalid_int_q && r_ready_int) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mem_rdata;
      out_last_q  <= rlast_int;
      out_id_q    <= r_id_q;
    end else if (s_axi_rready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign s_axi_rvalid = out_valid_q;
  assign s_axi_rdata  = out_data_q;
  assign s_axi_rlast  = out_last_q;
  assign s_axi_rid    = out_id_q;
`else
  assign r_ready_int  = s_axi_rready;
  assign s_axi_rvalid = rvalid_int_q;
  assign s_axi_rdata  = mem_rdata;
  assign s_axi_rlast  = rlast_int;
  assign s_axi_rid    = r_id_q;
`endif

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  axi_ram_mem #(
    .DATA_WIDTH      (DATA_WIDTH),
    .WORD_ADDR_WIDTH (WordAddrW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (word_idx(w_addr_q)),
    .wdata_i (s_axi_wdata),
    .wstrb_i (s_axi_wstrb),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_axi_ram.sv
// Self-checking bench for axi_ram: reset, single beat, INCR/FIXED bursts, byte strobes,
// backpressure on R and B, concurrent read/write and address aliasing.
module tb_axi_ram;

  localparam int DW  = 512;
  localparam int AW  = 64;
  localparam int SW  = DW / 8;
  localparam int IW  = 12;
  localparam int MAW = 20;
  localparam int TMO = 400;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] s_axi_awid = '0;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic [7:0]    s_axi_awlen = '0;
  logic [2:0]    s_axi_awsize = '0;
  logic [1:0]    s_axi_awburst = '0;
  logic [1:0]    s_axi_awlock = '0;
  logic [3:0]    s_axi_awcache = '0;
  logic [2:0]    s_axi_awprot = '0;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [SW-1:0] s_axi_wstrb = '0;
  logic          s_axi_wlast = 1'b0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [IW-1:0] s_axi_bid;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic [IW-1:0] s_axi_arid = '0;
  logic [AW-1:0] s_axi_araddr = '0;
  logic [7:0]    s_axi_arlen = '0;
  logic [2:0]    s_axi_arsize = '0;
  logic [1:0]    s_axi_arburst = '0;
  logic [1:0]    s_axi_arlock = '0;
  logic [3:0]    s_axi_arcache = '0;
  logic [2:0]    s_axi_arprot = '0;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [IW-1:0] s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;

  always #5 clk = ~clk;

  axi_ram #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .ID_WIDTH       (IW),
    .MEM_ADDR_WIDTH (MAW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awlock  (s_axi_awlock),
    .s_axi_awcache (s_axi_awcache),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arlock  (s_axi_arlock),
    .s_axi_arcache (s_axi_arcache),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] id;
  } rbeat_t;

  rbeat_t        rq[$];
  logic [DW-1:0] wbeats[256];
  logic [SW-1:0] wstrbs[256];
  logic [DW-1:0] exp_beats[256];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1);
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [IW-1:0] id, input int bdelay);
    int t;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = 3'd6;
    s_axi_awburst = burst; s_axi_awid = id; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin
      vectors++; miscompares++;
      $display("FAIL aw_timeout: actual awready=0 required awready=1");
      s_axi_awvalid = 1'b0;
      return;
    end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = wbeats[i]; s_axi_wstrb = wstrbs[i];
      s_axi_wlast = (i == int'(len)); s_axi_wvalid = 1'b1;
      t = 0;
      while (!s_axi_wready && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin
        vectors++; miscompares++;
        $display("FAIL w_timeout: beat %0d actual wready=0 required wready=1", i);
        s_axi_wvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    t = 0;
    while (!s_axi_bvalid && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin
      vectors++; miscompares++;
      $display("FAIL b_timeout: actual bvalid=0 required bvalid=1");
      return;
    end
    for (int d = 0; d < bdelay; d++) begin
      @(negedge clk);
      vectors++;
      if (s_axi_bvalid !== 1'b1) begin
        miscompares++;
        $display("FAIL b_hold: stall cycle %0d actual bvalid=%b required 1", d, s_axi_bvalid);
      end
    end
    s_axi_bready = 1'b1;
    vectors++;
    if (s_axi_bid !== id || s_axi_bresp !== 2'b00) begin
      miscompares++;
      $display("FAIL b_resp: actual bid=%h bresp=%b required bid=%h bresp=00",
               s_axi_bid, s_axi_bresp, id);
    end
    @(negedge clk);
    s_axi_bready = 1'b0;
    vectors++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      miscompares++;
      $display("FAIL b_done: actual bvalid=%b awready=%b required bvalid=0 awready=1",
               s_axi_bvalid, s_axi_awready);
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [IW-1:0] id, input bit toggle);
    int t;
    int got;
    int cyc;
    bit held_v;
    logic [DW-1:0] held_data;
    logic held_last;
    rbeat_t e;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = 3'd6;
    s_axi_arburst = burst; s_axi_arid = id; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = exp_beats[i]; e.last = (i == int'(len)); e.id = id;
      rq.push_back(e);
    end
    t = 0;
    while (!s_axi_arready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin
      vectors++; miscompares++;
      $display("FAIL ar_timeout: actual arready=0 required arready=1");
      s_axi_arvalid = 1'b0;
      rq.delete();
      return;
    end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
`ifdef AXI_RAM_PIPELINE_OUTPUT_EN
    vectors++;
    if (s_axi_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL r_latency: one cycle after AR actual rvalid=%b required 0", s_axi_rvalid);
    end
    @(negedge clk);
`endif
    vectors++;
    if (s_axi_rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL r_latency: first beat cycle actual rvalid=%b required 1", s_axi_rvalid);
    end
    got = 0; cyc = 0; held_v = 1'b0; held_data = '0; held_last = 1'b0;
    while (got <= int'(len) && cyc < TMO) begin
      s_axi_rready = toggle ? cyc[0] : 1'b1;
      if (held_v) begin
        held_v = 1'b0;
        vectors++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== held_data || s_axi_rlast !== held_last) begin
          miscompares++;
          $display("FAIL r_stall_hold: actual rvalid=%b rlast=%b rdata=%h required 1 %b %h",
                   s_axi_rvalid, s_axi_rlast, s_axi_rdata, held_last, held_data);
        end
      end
      if (s_axi_rvalid === 1'b1) begin
        if (s_axi_rready) begin
          vectors++;
          if (rq.size() == 0) begin
            miscompares++;
            $display("FAIL r_extra_beat: actual extra beat rdata=%h required none", s_axi_rdata);
          end else begin
            e = rq.pop_front();
            if (s_axi_rdata !== e.data || s_axi_rlast !== e.last || s_axi_rid !== e.id ||
                s_axi_rresp !== 2'b00) begin
              miscompares++;
              $display("FAIL r_beat%0d: actual rdata=%h rlast=%b rid=%h rresp=%b required rdata=%h rlast=%b rid=%h rresp=00",
                       got, s_axi_rdata, s_axi_rlast, s_axi_rid, s_axi_rresp,
                       e.data, e.last, e.id);
            end
          end
          got++;
        end else begin
          held_v = 1'b1; held_data = s_axi_rdata; held_last = s_axi_rlast;
        end
      end
      @(negedge clk);
      cyc++;
    end
    s_axi_rready = 1'b0;
    if (got <= int'(len)) begin
      vectors++; miscompares++;
      $display("FAIL r_timeout: actual beats=%0d required beats=%0d", got, int'(len) + 1);
      rq.delete();
      return;
    end
    vectors++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      miscompares++;
      $display("FAIL r_done: actual rvalid=%b arready=%b required rvalid=0 arready=1",
               s_axi_rvalid, s_axi_arready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (25) @(negedge clk);
    vectors++;
    if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid,
         s_axi_rlast} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: actual aw/ar/w/b/rv/rl=%b required 000000",
               {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid,
                s_axi_rlast});
    end
    vectors++;
    if (s_axi_bid !== '0 || s_axi_rid !== '0 || s_axi_bresp !== 2'b00 ||
        s_axi_rresp !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ids: actual bid=%h rid=%h bresp=%b rresp=%b required all 0",
               s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: actual awready=%b arready=%b required 1 1",
               s_axi_awready, s_axi_arready);
    end
  endtask

  task automatic test_single();
    wbeats[0] = {16{32'hDEADBEEF}}; wstrbs[0] = '1;
    axi_write(64'h40000, 8'd0, 2'b01, 12'h123, 0);
    exp_beats[0] = {16{32'hDEADBEEF}};
    axi_read(64'h40000, 8'd0, 2'b01, 12'h456, 1'b0);
  endtask

  task automatic test_incr_burst();
    logic [7:0] b;
    for (int i = 0; i < 32; i++) begin
      b = 8'(i);
      wbeats[i] = {16{b, 8'h3C, ~b, 8'hC3}}; wstrbs[i] = '1;
      exp_beats[i] = {16{b, 8'h3C, ~b, 8'hC3}};
    end
    axi_write(64'h0, 8'd31, 2'b01, 12'h00A, 0);
    axi_read(64'h0, 8'd31, 2'b01, 12'h00B, 1'b0);
  endtask

  task automatic test_strobes();
    wbeats[0] = '1; wstrbs[0] = '1;
    axi_write(64'h1000, 8'd0, 2'b01, 12'h011, 0);
    wbeats[0] = '0; wstrbs[0] = 64'h0F;
    axi_write(64'h1000, 8'd0, 2'b01, 12'h012, 0);
    exp_beats[0] = {{60{8'hFF}}, 32'h0};
    axi_read(64'h1000, 8'd0, 2'b01, 12'h013, 1'b0);
  endtask

  task automatic test_fixed_burst();
    for (int i = 0; i < 4; i++) begin
      wbeats[i] = {16{32'hF1C0_0000 | 32'(i)}}; wstrbs[i] = '1;
    end
    axi_write(64'h5000, 8'd3, 2'b00, 12'h021, 0);
    exp_beats[0] = {16{32'hF1C0_0003}};
    exp_beats[1] = {16{32'hF1C0_0003}};
    axi_read(64'h5000, 8'd1, 2'b00, 12'h022, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      wbeats[i] = {16{32'hB0B0_0000 | 32'(i * 7 + 1)}}; wstrbs[i] = '1;
      exp_beats[i] = {16{32'hB0B0_0000 | 32'(i * 7 + 1)}};
    end
    axi_write(64'h2000, 8'd3, 2'b01, 12'h031, 5);
    axi_read(64'h2000, 8'd3, 2'b01, 12'h032, 1'b1);
  endtask

  task automatic test_concurrent();
    wbeats[0] = {16{32'h1234_5678}}; wbeats[1] = {16{32'h9ABC_DEF0}};
    wstrbs[0] = '1; wstrbs[1] = '1;
    exp_beats[0] = {16{32'hDEADBEEF}};
    fork
      axi_write(64'h3000, 8'd1, 2'b01, 12'h041, 0);
      axi_read(64'h40000, 8'd0, 2'b01, 12'h042, 1'b0);
    join
    exp_beats[0] = {16{32'h1234_5678}}; exp_beats[1] = {16{32'h9ABC_DEF0}};
    axi_read(64'h3000, 8'd1, 2'b01, 12'h043, 1'b0);
  endtask

  task automatic test_alias();
    wbeats[0] = {16{32'hA11A_5ED0}}; wstrbs[0] = '1;
    axi_write(64'h1 << MAW, 8'd0, 2'b01, 12'h051, 0);
    exp_beats[0] = {16{32'hA11A_5ED0}};
    axi_read(64'h0, 8'd0, 2'b01, 12'h052, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_strobes();
    test_fixed_burst();
    test_backpressure();
    test_concurrent();
    test_alias();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_ram.md
Name: axi_ram

Overview:
- AXI4 memory-mapped slave backed by an on-chip byte-enabled RAM.
- Serves as the external/host memory model that the Briey SoC wrapper masters in system simulation.
- Independent read and write engines; FIXED and INCR bursts; each engine handles one burst at a time.

Parameters:
- DATA_WIDTH, 512, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 64, AXI address width in bits.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width; derived, not overridden.
- ID_WIDTH, 12, AXI ID width in bits.
- MEM_ADDR_WIDTH, 20, implemented byte-address bits. Address bits above this are ignored, so higher addresses alias. Depth is 2^MEM_ADDR_WIDTH/STRB_WIDTH words.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  ID_WIDTH/ADDR_WIDTH/8/3/2/2/4/3  write address. lock, cache and prot are ignored.
- s_axi_awvalid in 1, s_axi_awready out 1  AW handshake.
- s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/STRB_WIDTH/1  write data.
- s_axi_wvalid in 1, s_axi_wready out 1  W handshake.
- s_axi_bid/bresp  out  ID_WIDTH/2  write response.
- s_axi_bvalid out 1, s_axi_bready in 1  B handshake.
- s_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  same widths as the AW group  read address.
- s_axi_arvalid in 1, s_axi_arready out 1  AR handshake.
- s_axi_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data.
- s_axi_rvalid out 1, s_axi_rready in 1  R handshake.

Behaviour:
- Reset (async assert, sync deassert use): awready=arready=wready=bvalid=rvalid=rlast=0; bid=rid=0; bresp=rresp=0; both FSMs go to IDLE. RAM contents are not reset.
- Reset mid-burst aborts the burst with no response; RAM keeps any beats already written.
- Word index = addr[MEM_ADDR_WIDTH-1:log2(STRB_WIDTH)].
- Address update per beat:
  - INCR: addr += 2^size.
  - FIXED: addr unchanged.
  - WRAP: treated as INCR.
  - Any burst type: bresp/rresp always 2'b00 (OKAY).
- Write FSM, IDLE -> WRITE -> RESP -> IDLE:
  - IDLE: awready=1. On the awvalid&awready cycle, latch id, addr, len, size and burst; go to WRITE.
  - WRITE: wready=1. Each wvalid&wready beat writes the bytes whose wstrb bit is 1, then advances addr.
  - WRITE exits after len+1 beats, counted by the beat counter. wlast is ignored.
  - RESP: bvalid=1, bid=latched id; hold until bready. On the bvalid&bready cycle, go to IDLE with awready=1 in the next cycle.
  - Minimum cycles from AW handshake to bvalid: len+2.
- Read FSM, IDLE -> READ -> IDLE:
  - IDLE: arready=1. On the AR handshake, latch id, addr, len, size and burst.
  - Latency: rvalid rises one cycle after the AR handshake (registered RAM read).
  - rdata, rid and rlast are held stable while rvalid=1 and rready=0.
  - Each rvalid&rready beat advances to the next address. rlast=1 on beat len only.
  - After the final handshake, rvalid=0 and arready=1 in the next cycle.
  - Back-to-back beats at full throughput when rready is held high.
- Read and write engines run concurrently. A same-cycle read and write to the same word is read-first: the read returns the old data.
- arlen=0 / awlen=0 gives a single beat; rlast=1 on that beat.
- len up to 255 is supported. Burst-length counter is 8 bits.

Optional Feature:
- Macro: AXI_RAM_PIPELINE_OUTPUT_EN.
- When defined: an extra output register on the R channel. First rvalid comes two cycles after the AR handshake; full throughput and backpressure correctness are kept (skid/output register).
- When undefined: one-cycle latency as described above.

Decomposition:
- Package axi_ram_pkg:
  - burst constants BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
  - RESP_OKAY=2'b00.
  - write_state_t {W_IDLE, W_DATA, W_RESP} and read_state_t {R_IDLE, R_DATA}.
- One sub-module, axi_ram_mem: simple dual-port RAM with a byte-enabled write port and a registered read port with read-enable. The top holds both FSMs and the address generators.

Test Plan:
- Reset: hold rst_n=0 for 25 cycles -> all valid/ready outputs 0; after release, awready=1 and arready=1.
- Single write then read: write awaddr=0x40000, awlen=0, wdata=0x...DEADBEEF, wstrb all ones -> bvalid with bid=awid, bresp=0. Then read araddr=0x40000 -> rdata=0x...DEADBEEF, rlast=1, rid=arid, rvalid one cycle after the AR handshake.
- INCR burst: awaddr=0, awlen=31, awsize=6, 32 distinct beats; read back with arlen=31 -> 32 matching beats, rlast only on beat 31.
- Byte strobes: write all-ones to a word, then write 0 with wstrb=64'h0F -> readback has bytes 0-3 = 0 and bytes 4-63 = 0xFF.
- Backpressure: read burst arlen=3 with rready toggled every other cycle, and B with bready delayed 5 cycles -> data stable while stalled, no beats lost or duplicated, bvalid held for the 5 cycles.
- Concurrency/aliasing: read and write to different words at the same time -> both complete correctly. Write at 2^MEM_ADDR_WIDTH -> data appears at address 0.
